// File: rtl/pw_trigger_sequencer_pkg.sv
// Shared encodings and default field widths for the front-end multi-pulse trigger sequencer.
package pw_trigger_sequencer_pkg;

  typedef enum logic [1:0] {
    TRIGSEQ_IDLE  = 2'd0,
    TRIGSEQ_DELAY = 2'd1,
    TRIGSEQ_PULSE = 2'd2,
    TRIGSEQ_DONE  = 2'd3
  } trigseq_state_e;

  localparam int TRIGSEQ_MAX_PULSES  = 8;
  localparam int TRIGSEQ_NUM_WIDTH   = 4;
  localparam int TRIGSEQ_DELAY_WIDTH = 24;
  localparam int TRIGSEQ_WIDTH_WIDTH = 24;

endpackage

// File: rtl/pw_trigger_sequencer.sv
// Emits one to eight programmable delay/width pulses after an armed pattern match,
// followed by a one-cycle completion strobe. All outputs are registered.
module pw_trigger_sequencer
  import pw_trigger_sequencer_pkg::*;
#(
  parameter int pNUM_TRIGGER_PULSES = TRIGSEQ_MAX_PULSES,
  parameter int pNUM_TRIGGER_WIDTH  = TRIGSEQ_NUM_WIDTH,
  parameter int pDELAY_WIDTH        = TRIGSEQ_DELAY_WIDTH,
  parameter int pWIDTH_WIDTH        = TRIGSEQ_WIDTH_WIDTH
) (
  input  logic                                        fe_clk,
  input  logic                                        reset_i,
  input  logic [pDELAY_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_delay,
  input  logic [pWIDTH_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_width,
  input  logic [pNUM_TRIGGER_WIDTH-1:0]               I_num_triggers,
  input  logic                                        I_trigger_enable,
  input  logic                                        I_arm,
  input  logic                                        I_match,
  output logic                                        O_trigger,
  output logic                                        O_busy,
  output logic [2:0]                                  O_pulse_index,
  output logic                                        O_done
);

  localparam int CNT_W = (pDELAY_WIDTH > pWIDTH_WIDTH) ? pDELAY_WIDTH : pWIDTH_WIDTH;
  localparam int IDX_W = 3;

  trigseq_state_e                              state;
  logic [CNT_W-1:0]                            counter;
  logic [IDX_W-1:0]                            index;
  logic [IDX_W-1:0]                            last_index;
  logic [pDELAY_WIDTH*pNUM_TRIGGER_PULSES-1:0] delay_q;
  logic [pWIDTH_WIDTH*pNUM_TRIGGER_PULSES-1:0] width_q;

  logic             start;
  logic [IDX_W-1:0] index_inc;
  logic [CNT_W-1:0] start_delay, start_width, cur_width, next_delay, next_width;

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] eff_last(input logic [pNUM_TRIGGER_WIDTH-1:0] n);
    if (int'(n) == 0) return '0;
    if (int'(n) >= pNUM_TRIGGER_PULSES) return IDX_W'(pNUM_TRIGGER_PULSES - 1);
    return IDX_W'(int'(n) - 1);
  endfunction

  assign start       = I_match & I_arm & I_trigger_enable;
  assign index_inc   = index + IDX_W'(1);
  assign start_delay = CNT_W'(I_trigger_delay[pDELAY_WIDTH-1:0]);
  assign start_width = CNT_W'(I_trigger_width[pWIDTH_WIDTH-1:0]);
  assign cur_width   = CNT_W'(width_q[int'(index) * pWIDTH_WIDTH +: pWIDTH_WIDTH]);
  assign next_delay  = CNT_W'(delay_q[int'(index_inc) * pDELAY_WIDTH +: pDELAY_WIDTH]);
  assign next_width  = CNT_W'(width_q[int'(index_inc) * pWIDTH_WIDTH +: pWIDTH_WIDTH]);

  assign O_pulse_index = index;

  // NOTE: snapshot registers are only read while busy and are always loaded on start,
  // so they carry no reset and stay out of the reset fan-out.
  always_ff @(posedge fe_clk) begin
    if (state == TRIGSEQ_IDLE && start) begin
      delay_q    <= I_trigger_delay;
      width_q    <= I_trigger_width;
      last_index <= eff_last(I_num_triggers);
    end
  end

  // Counters are loaded with length-1 so a phase of length L occupies exactly L cycles;
  // a zero delay skips the DELAY state entirely.
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state     <= TRIGSEQ_IDLE;
      counter   <= '0;
      index     <= '0;
      O_trigger <= 1'b0;
      O_busy    <= 1'b0;
      O_done    <= 1'b0;
    end else begin
      O_done <= 1'b0;
      case (state)
        TRIGSEQ_IDLE: begin
          if (start) begin
            index  <= '0;
            O_busy <= 1'b1;
            if (start_delay == '0) begin
              state     <= TRIGSEQ_PULSE;
              counter   <= dec_sat(start_width);
              O_trigger <= 1'b1;
            end else begin
              state   <= TRIGSEQ_DELAY;
              counter <= dec_sat(start_delay);
            end
          end
        end
        TRIGSEQ_DELAY: begin
          if (counter == '0) begin
            state     <= TRIGSEQ_PULSE;
            counter   <= dec_sat(cur_width);
            O_trigger <= 1'b1;
          end else begin
            counter <= dec_sat(counter);
          end
        end
        TRIGSEQ_PULSE: begin
          if (counter != '0) begin
            counter <= dec_sat(counter);
          end else if (index == last_index) begin
            state     <= TRIGSEQ_DONE;
            O_trigger <= 1'b0;
            O_done    <= 1'b1;
          end else begin
            index <= index_inc;
            if (next_delay == '0) begin
              counter <= dec_sat(next_width);
            end else begin
              state     <= TRIGSEQ_DELAY;
              counter   <= dec_sat(next_delay);
              O_trigger <= 1'b0;
            end
          end
        end
        TRIGSEQ_DONE: begin
          state  <= TRIGSEQ_IDLE;
          index  <= '0;
          O_busy <= 1'b0;
        end
        default: state <= TRIGSEQ_IDLE;
      endcase

      // NOTE: the abort is written after the case so its non-blocking updates override
      // whatever the case scheduled on the same edge.
      if (state != TRIGSEQ_IDLE && !I_trigger_enable) begin
        state     <= TRIGSEQ_IDLE;
        index     <= '0;
        O_trigger <= 1'b0;
        O_busy    <= 1'b0;
        O_done    <= 1'b0;
      end
    end
  end

endmodule
